// File: rtl/muldiv_ctrl_pkg.sv
// Shared types for the multi-cycle multiply/divide unit: funct codes, FSM states
// and the iteration count.
package muldiv_ctrl_pkg;

    localparam int MULDIV_ITERS = 32;

    typedef enum logic [5:0] {
        FUNCT_MTHI  = 6'h11,
        FUNCT_MTLO  = 6'h13,
        FUNCT_MULT  = 6'h18,
        FUNCT_MULTU = 6'h19,
        FUNCT_DIV   = 6'h1A,
        FUNCT_DIVU  = 6'h1B
    } funct_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } muldiv_state_t;

    // Two's-complement magnitude when neg is set, raw value otherwise.
    function automatic logic [31:0] mag32(input logic [31:0] v, input logic neg);
        logic [31:0] r;
        if (neg) begin
            r = 32'd0 - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the mul/div datapath: shift-add multiply step (LSB first) or
// restoring-divide step (MSB first). The quotient bit is merged in by the caller.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   opnd,
    input  logic               in_bit,
    input  logic               is_div,
    output logic [2*WIDTH-1:0] acc_next,
    output logic               qbit
);

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   shifted_s;
    logic             ge_s;
    logic [WIDTH-1:0] rem_s;

    // Compute both step variants and select by operation class.
    always_comb begin
        sum_s     = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (in_bit ? opnd : {WIDTH{1'b0}})};
        shifted_s = {acc[2*WIDTH-1:WIDTH], in_bit};
        ge_s      = (shifted_s >= {1'b0, opnd});
        rem_s     = shifted_s[WIDTH-1:0];
        qbit      = 1'b0;
        acc_next  = {sum_s, acc[WIDTH-1:1]};
        if (is_div) begin
            // The true difference always fits in WIDTH bits when no borrow occurs.
            if (ge_s) begin
                rem_s = shifted_s[WIDTH-1:0] - opnd;
                qbit  = 1'b1;
            end else begin
                rem_s = shifted_s[WIDTH-1:0];
                qbit  = 1'b0;
            end
            acc_next = {rem_s, acc[WIDTH-2:0], 1'b0};
        end else begin
            qbit     = 1'b0;
            acc_next = {sum_s, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// MULT/MULTU/DIV/DIVU/MTHI/MTLO sequencer owning HI/LO.
// Optional flush support: define MULDIV_ABORT_EN to add the abort input.
module muldiv_ctrl
    import muldiv_ctrl_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  funct_t           fncode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef MULDIV_ABORT_EN
    input  logic             abort,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(MULDIV_ITERS);

    muldiv_state_t      state_r;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [WIDTH-1:0]   opa_r;
    logic [WIDTH-1:0]   opb_r;
    logic               is_div_r;
    logic               neg_q_r;
    logic               neg_r_r;
    logic [WIDTH-1:0]   hi_r;
    logic [WIDTH-1:0]   lo_r;
    logic               done_r;

    logic               is_op_s;
    logic               is_div_s;
    logic               is_signed_s;
    logic               sa_s;
    logic               sb_s;
    logic [WIDTH-1:0]   amag_s;
    logic [WIDTH-1:0]   bmag_s;
    logic               in_bit_s;
    logic [2*WIDTH-1:0] step_acc_s;
    logic               step_qbit_s;
    logic [2*WIDTH-1:0] prod_s;
    logic [WIDTH-1:0]   res_hi_s;
    logic [WIDTH-1:0]   res_lo_s;
    logic               abort_s;

    assign busy = (state_r != IDLE);
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

    // Classify the requested funct code.
    always_comb begin
        is_op_s     = 1'b0;
        is_div_s    = 1'b0;
        is_signed_s = 1'b0;
        case (fncode)
            FUNCT_MULT:  begin is_op_s = 1'b1; is_signed_s = 1'b1; end
            FUNCT_MULTU: begin is_op_s = 1'b1; end
            FUNCT_DIV:   begin is_op_s = 1'b1; is_div_s = 1'b1; is_signed_s = 1'b1; end
            FUNCT_DIVU:  begin is_op_s = 1'b1; is_div_s = 1'b1; end
            default:     begin is_op_s = 1'b0; end
        endcase
    end

    assign sa_s     = is_signed_s & a[WIDTH-1];
    assign sb_s     = is_signed_s & b[WIDTH-1];
    assign amag_s   = mag32(a, sa_s);
    assign bmag_s   = mag32(b, sb_s);
    assign in_bit_s = is_div_r ? opb_r[WIDTH-1] : opb_r[0];

    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .acc      (acc_r),
        .opnd     (opa_r),
        .in_bit   (in_bit_s),
        .is_div   (is_div_r),
        .acc_next (step_acc_s),
        .qbit     (step_qbit_s)
    );

    // Abort only acts while an operation is in flight.
    always_comb begin
`ifdef MULDIV_ABORT_EN
        abort_s = abort & (state_r != IDLE);
`else
        abort_s = 1'b0;
`endif
    end

    // Sign correction of the finished magnitude result.
    always_comb begin
        prod_s   = {(2*WIDTH){1'b0}} - acc_r;
        res_hi_s = acc_r[2*WIDTH-1:WIDTH];
        res_lo_s = acc_r[WIDTH-1:0];
        if (is_div_r) begin
            if (neg_q_r) begin
                res_lo_s = {WIDTH{1'b0}} - acc_r[WIDTH-1:0];
            end else begin
                res_lo_s = acc_r[WIDTH-1:0];
            end
            if (neg_r_r) begin
                res_hi_s = {WIDTH{1'b0}} - acc_r[2*WIDTH-1:WIDTH];
            end else begin
                res_hi_s = acc_r[2*WIDTH-1:WIDTH];
            end
        end else begin
            if (neg_q_r) begin
                {res_hi_s, res_lo_s} = prod_s;
            end else begin
                {res_hi_s, res_lo_s} = acc_r;
            end
        end
    end

    // Sequencer state, iteration datapath and HI/LO registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= {CW{1'b0}};
            acc_r    <= {(2*WIDTH){1'b0}};
            opa_r    <= {WIDTH{1'b0}};
            opb_r    <= {WIDTH{1'b0}};
            is_div_r <= 1'b0;
            neg_q_r  <= 1'b0;
            neg_r_r  <= 1'b0;
            hi_r     <= {WIDTH{1'b0}};
            lo_r     <= {WIDTH{1'b0}};
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            if (abort_s) begin
                state_r <= IDLE;
                cnt_r   <= {CW{1'b0}};
            end else begin
                case (state_r)
                    IDLE: begin
                        if (start) begin
                            case (fncode)
                                FUNCT_MTHI: begin hi_r <= a; done_r <= 1'b1; end
                                FUNCT_MTLO: begin lo_r <= a; done_r <= 1'b1; end
                                default: begin
                                    if (is_op_s && is_div_s && (b == {WIDTH{1'b0}})) begin
                                        done_r <= 1'b1;
                                    end else if (is_op_s) begin
                                        // Divide keeps the divisor in opa and shifts the dividend out of opb.
                                        opa_r    <= is_div_s ? bmag_s : amag_s;
                                        opb_r    <= is_div_s ? amag_s : bmag_s;
                                        is_div_r <= is_div_s;
                                        neg_q_r  <= sa_s ^ sb_s;
                                        neg_r_r  <= sa_s;
                                        acc_r    <= {(2*WIDTH){1'b0}};
                                        cnt_r    <= {CW{1'b0}};
                                        state_r  <= RUN;
                                    end else begin
                                        state_r <= IDLE;
                                    end
                                end
                            endcase
                        end else begin
                            state_r <= IDLE;
                        end
                    end
                    RUN: begin
                        acc_r <= is_div_r ? {step_acc_s[2*WIDTH-1:1], step_qbit_s} : step_acc_s;
                        opb_r <= is_div_r ? (opb_r << 1) : (opb_r >> 1);
                        if (cnt_r == CW'(MULDIV_ITERS - 1)) begin
                            cnt_r   <= {CW{1'b0}};
                            state_r <= FIX;
                        end else begin
                            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
                        end
                    end
                    FIX: begin
                        hi_r    <= res_hi_s;
                        lo_r    <= res_lo_s;
                        done_r  <= 1'b1;
                        state_r <= IDLE;
                    end
                    default: begin
                        state_r <= IDLE;
                        cnt_r   <= {CW{1'b0}};
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed self-checking bench for muldiv_ctrl; hand-computed expected HI/LO,
// latency and busy/done behaviour.
module tb_muldiv_ctrl;
    import muldiv_ctrl_pkg::*;

    logic        clk;
    logic        rst_n;
    logic        start;
    funct_t      fncode;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;
`ifdef MULDIV_ABORT_EN
    logic        abort;
`endif

    int checks;
    int errors;

    muldiv_ctrl #(.WIDTH(32)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .fncode (fncode),
        .a      (a),
        .b      (b),
`ifdef MULDIV_ABORT_EN
        .abort  (abort),
`endif
        .busy   (busy),
        .done   (done),
        .hi     (hi),
        .lo     (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic issue(input funct_t f, input logic [31:0] av, input logic [31:0] bv);
        @(negedge clk);
        fncode = f;
        a      = av;
        b      = bv;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = 32'hDEADBEEF;
        b     = 32'h0BAD0BAD;
    endtask

    // lat counts clock edges after the start edge before done is seen.
    task automatic wait_done(output int lat, output int busy_n);
        lat    = 0;
        busy_n = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (done) break;
            lat++;
            if (busy) busy_n++;
        end
        check("done_seen", {63'd0, done}, 64'd1);
    endtask

    task automatic count_done(input int n, output int pulses);
        pulses = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (done) pulses++;
        end
    endtask

    initial begin
        int lat;
        int bn;
        int np;
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        start  = 1'b0;
        fncode = FUNCT_MTHI;
        a      = 32'd0;
        b      = 32'd0;
`ifdef MULDIV_ABORT_EN
        abort  = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        rst_n = 1'b1;

        // MTHI then MTLO on consecutive cycles.
        @(negedge clk);
        fncode = FUNCT_MTHI; a = 32'h12345678; start = 1'b1;
        @(posedge clk);
        #1;
        fncode = FUNCT_MTLO; a = 32'h9ABCDEF0;
        @(negedge clk);
        check("mthi_hi", {32'd0, hi}, 64'h12345678);
        check("mthi_done_busy", {62'd0, done, busy}, 64'd2);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("mtlo_lo", {32'd0, lo}, 64'h9ABCDEF0);
        check("mtlo_done_busy", {62'd0, done, busy}, 64'd2);
        @(negedge clk);
        check("mtlo_done_drop", {63'd0, done}, 64'd0);

        issue(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        wait_done(lat, bn);
        check("multu_lat", 64'(lat), 64'd33);
        check("multu_busy_cycles", 64'(bn), 64'd33);
        check("multu_hilo", {hi, lo}, 64'hFFFFFFFE_00000001);
        check("multu_busy_after", {63'd0, busy}, 64'd0);
        @(negedge clk);
        check("multu_done_pulse", {63'd0, done}, 64'd0);

        issue(FUNCT_MULT, 32'hFFFFFFF9, 32'd6);
        wait_done(lat, bn);
        check("mult_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFD6);

        issue(FUNCT_DIV, 32'hFFFFFFF9, 32'd2);
        wait_done(lat, bn);
        check("div_neg_hilo", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);

        issue(FUNCT_DIVU, 32'd100, 32'd7);
        wait_done(lat, bn);
        check("divu_hilo", {hi, lo}, {32'd2, 32'd14});
        check("divu_lat", 64'(lat), 64'd33);

        issue(FUNCT_DIV, 32'h80000000, 32'hFFFFFFFF);
        wait_done(lat, bn);
        check("div_ovf_hilo", {hi, lo}, 64'h00000000_80000000);

        issue(FUNCT_DIVU, 32'd5, 32'd0);
        wait_done(lat, bn);
        check("div0_lat", 64'(lat), 64'd0);
        check("div0_busy", {63'd0, busy}, 64'd0);
        check("div0_hilo", {hi, lo}, 64'h00000000_80000000);

        issue(funct_t'(6'h20), 32'd1, 32'd1);
        count_done(4, np);
        check("bad_funct_done", 64'(np), 64'd0);
        check("bad_funct_busy", {63'd0, busy}, 64'd0);
        check("bad_funct_hilo", {hi, lo}, 64'h00000000_80000000);

        // A second start while busy must be dropped.
        issue(FUNCT_MULTU, 32'd3, 32'd5);
        repeat (3) @(negedge clk);
        issue(FUNCT_MULTU, 32'd7, 32'd7);
        wait_done(lat, bn);
        check("ignore_hilo", {hi, lo}, 64'd15);
        count_done(40, np);
        check("ignore_no_second", 64'(np), 64'd0);

`ifdef MULDIV_ABORT_EN
        issue(FUNCT_MTHI, 32'h5555AAAA, 32'd0);
        wait_done(lat, bn);
        issue(FUNCT_MULT, 32'd3, 32'd4);
        repeat (6) @(negedge clk);
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        check("abort_busy", {63'd0, busy}, 64'd0);
        check("abort_done", {63'd0, done}, 64'd0);
        count_done(40, np);
        check("abort_no_done", 64'(np), 64'd0);
        check("abort_hilo", {hi, lo}, {32'h5555AAAA, 32'd15});
`endif

        // Asynchronous reset in the middle of an operation.
        issue(FUNCT_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        repeat (11) @(negedge clk);
        check("midrst_busy_before", {63'd0, busy}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_hilo", {hi, lo}, 64'd0);
        check("midrst_done", {63'd0, done}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        count_done(40, np);
        check("midrst_no_done", 64'(np), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
